// File: rtl/usb_audio_pkg.sv
// Shared types, constants and parameter helpers for the USB audio stream sink.
package usb_audio_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } state_t;

   localparam int unsigned BYTE_BITS = 8;

   // Width of one assembled frame: all channels side by side.
   function automatic int unsigned frame_width(input int unsigned channels,
                                               input int unsigned sample_bytes);
      return channels * sample_bytes * BYTE_BITS;
   endfunction

   // Legal parameter set: 1..8 channels, 2 or 3 byte samples, power-of-2 depth >= 4.
   function automatic bit params_ok(input int unsigned channels,
                                    input int unsigned sample_bytes,
                                    input int unsigned fifo_depth);
      return (channels >= 1) && (channels <= 8) &&
             ((sample_bytes == 2) || (sample_bytes == 3)) &&
             (fifo_depth >= 4) && ((fifo_depth & (fifo_depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/usb_frame_fifo.sv
// Single-clock frame FIFO with registered read data, flush and occupancy.
module usb_frame_fifo #(
   parameter  int unsigned WIDTH = 32,
   parameter  int unsigned DEPTH = 64,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             rd_clear,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic [AW:0]      fill
);

   localparam int unsigned FW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_q;
   logic [AW:0]      rd_q;
   logic             push_ok_c;
   logic             pop_ok_c;

   // Never write past full or read past empty, and nothing moves during a flush.
   assign push_ok_c = push && !flush && (fill != FW'(DEPTH));
   assign pop_ok_c  = pop  && !flush && (fill != '0);

   // Storage array, written on accepted pushes only.
   always_ff @(posedge clk) begin
      if (push_ok_c) begin
         mem[wr_q[AW-1:0]] <= wdata;
      end
   end

   // Pointers, occupancy and read data register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         fill  <= '0;
         rdata <= '0;
      end else if (flush) begin
         wr_q  <= '0;
         rd_q  <= '0;
         fill  <= '0;
         rdata <= '0;
      end else begin
         if (push_ok_c) begin
            wr_q <= wr_q + FW'(1);
         end
         if (pop_ok_c) begin
            rd_q <= rd_q + FW'(1);
         end
         fill <= fill + FW'(push_ok_c) - FW'(pop_ok_c);
         if (rd_clear) begin
            rdata <= '0;
         end else if (pop_ok_c) begin
            rdata <= mem[rd_q[AW-1:0]];
         end
      end
   end

endmodule

// File: rtl/usb_stream_multi.sv
// Isochronous OUT stream sink: assembles N-channel PCM frames from bytes,
// buffers them and releases one frame per falling edge of Audio_Clk.
module usb_stream_multi
   import usb_audio_pkg::*;
#(
   parameter  int unsigned CHANNELS     = 2,
   parameter  int unsigned SAMPLE_BYTES = 2,
   parameter  int unsigned FIFO_DEPTH   = 64,
   localparam int unsigned SAMPLE_BITS  = SAMPLE_BYTES * BYTE_BITS,
   localparam int unsigned AW           = $clog2(FIFO_DEPTH)
) (
   input  logic                            Clk,
   input  logic                            nReset,
   input  logic                            Enable,
   input  logic                            OUT_SoP,
   input  logic                            OUT_EoP,
   input  logic [7:0]                      OUT_Data,
   input  logic                            OUT_Valid,
   output logic                            OUT_WaitRequest,
   output logic                            OUT_Isochronous,
   output logic                            Stall,
   input  logic                            Audio_Clk,
   output logic [CHANNELS*SAMPLE_BITS-1:0] Audio,
   output logic [AW:0]                     Fill,
   output logic                            Overflow,
   output logic                            Underflow,
   output logic                            FrameError
);

   localparam int unsigned FRAME_W = frame_width(CHANNELS, SAMPLE_BYTES);
   localparam int unsigned NB      = CHANNELS * SAMPLE_BYTES;
   localparam int unsigned BW      = (SAMPLE_BYTES > 1) ? $clog2(SAMPLE_BYTES) : 1;
   localparam int unsigned CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int unsigned IW      = $clog2(NB);
   localparam int unsigned FILL_W  = AW + 1;
   localparam int unsigned HALF    = FIFO_DEPTH / 2;

   // Reject unsupported parameter sets at elaboration.
   if (!params_ok(CHANNELS, SAMPLE_BYTES, FIFO_DEPTH)) begin : g_param_check
      $error("usb_stream_multi: unsupported CHANNELS/SAMPLE_BYTES/FIFO_DEPTH");
   end

   state_t               state_q;
   state_t               state_d;
   logic                 sync1_q;
   logic                 sync2_q;
   logic                 sync3_q;
   logic                 tick_c;
   logic [BW-1:0]        b_q;
   logic [BW-1:0]        b_eff_c;
   logic [BW-1:0]        b_d;
   logic [CW-1:0]        c_q;
   logic [CW-1:0]        c_eff_c;
   logic [CW-1:0]        c_d;
   logic [IW-1:0]        idx_c;
   logic [FRAME_W-1:0]   asm_q;
   logic [FRAME_W-1:0]   frame_c;
   logic                 accept_c;
   logic                 byte_c;
   logic                 last_c;
   logic                 push_c;
   logic                 pop_c;
   logic                 flush_c;
   logic                 rd_clear_c;
   logic                 ovf_c;
   logic                 unf_c;
   logic                 ferr_c;

   // Isochronous endpoint never back-pressures or stalls.
   assign OUT_WaitRequest = 1'b0;
   assign OUT_Isochronous = 1'b1;
   assign Stall           = 1'b0;

   // Two-flop synchroniser plus history flop for falling-edge detection.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
      end else begin
         sync1_q <= Audio_Clk;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   assign tick_c = sync3_q & ~sync2_q;

   // State register.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, byte acceptance, pop and underflow decisions.
   always_comb begin
      state_d    = state_q;
      accept_c   = 1'b0;
      pop_c      = 1'b0;
      unf_c      = 1'b0;
      flush_c    = 1'b0;
      rd_clear_c = 1'b0;
      case (state_q)
         IDLE: begin
            flush_c = 1'b1;
            state_d = PRIME;
         end
         PRIME: begin
            accept_c = 1'b1;
            if (Fill >= FILL_W'(HALF)) begin
               state_d = RUN;
            end
         end
         RUN: begin
            accept_c = 1'b1;
            if (tick_c) begin
               if (Fill != '0) begin
                  pop_c = 1'b1;
               end else begin
                  unf_c      = 1'b1;
                  rd_clear_c = 1'b1;
                  state_d    = PRIME;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Disable overrides everything: flush and idle on the same edge.
      if (!Enable) begin
         state_d    = IDLE;
         accept_c   = 1'b0;
         pop_c      = 1'b0;
         unf_c      = 1'b0;
         rd_clear_c = 1'b0;
         flush_c    = 1'b1;
      end
   end

   // Byte placement, counter advance, frame completion and realignment.
   always_comb begin
      b_eff_c = OUT_SoP ? '0 : b_q;
      c_eff_c = OUT_SoP ? '0 : c_q;
      idx_c   = IW'(c_eff_c) * IW'(SAMPLE_BYTES) + IW'(b_eff_c);
      byte_c  = accept_c && OUT_Valid;
      last_c  = byte_c && (b_eff_c == BW'(SAMPLE_BYTES - 1)) &&
                (c_eff_c == CW'(CHANNELS - 1));
      frame_c = asm_q;
      for (int unsigned i = 0; i < NB; i++) begin
         if (IW'(i) == idx_c) begin
            frame_c[i*BYTE_BITS +: BYTE_BITS] = OUT_Data;
         end
      end
      b_d    = b_eff_c;
      c_d    = c_eff_c;
      ferr_c = 1'b0;
      if (byte_c) begin
         if (b_eff_c == BW'(SAMPLE_BYTES - 1)) begin
            b_d = '0;
            c_d = (c_eff_c == CW'(CHANNELS - 1)) ? '0 : c_eff_c + CW'(1);
         end else begin
            b_d = b_eff_c + BW'(1);
         end
      end
      if (OUT_EoP && ((b_d != '0) || (c_d != '0))) begin
         ferr_c = 1'b1;
         b_d    = '0;
         c_d    = '0;
      end
      if (!accept_c) begin
         ferr_c = 1'b0;
         b_d    = '0;
         c_d    = '0;
      end
      push_c = last_c && (Fill != FILL_W'(FIFO_DEPTH));
      ovf_c  = last_c && (Fill == FILL_W'(FIFO_DEPTH));
   end

   // Assembler counters, assembly register and status pulses.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         b_q        <= '0;
         c_q        <= '0;
         asm_q      <= '0;
         Overflow   <= 1'b0;
         Underflow  <= 1'b0;
         FrameError <= 1'b0;
      end else begin
         b_q        <= b_d;
         c_q        <= c_d;
         if (!accept_c) begin
            asm_q <= '0;
         end else if (byte_c) begin
            asm_q <= frame_c;
         end
         Overflow   <= ovf_c;
         Underflow  <= unf_c;
         FrameError <= ferr_c;
      end
   end

   // Frame buffer; its read register drives Audio directly.
   usb_frame_fifo #(
      .WIDTH (FRAME_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (Clk),
      .rst_n    (nReset),
      .flush    (flush_c),
      .rd_clear (rd_clear_c),
      .push     (push_c),
      .wdata    (frame_c),
      .pop      (pop_c),
      .rdata    (Audio),
      .fill     (Fill)
   );

endmodule

// File: tb/tb_usb_stream_multi.sv
// Bench for usb_stream_multi: a stereo 16-bit instance and a 6-channel 24-bit
// instance share the OUT bus and Audio_Clk; each is enabled in turn.
module tb_usb_stream_multi;

   localparam int unsigned DEPTH_A = 64;
   localparam int unsigned DEPTH_B = 8;

   logic         clk = 1'b0;
   logic         n_reset;
   logic         enable_a;
   logic         enable_b;
   logic         out_sop;
   logic         out_eop;
   logic [7:0]   out_data;
   logic         out_valid;
   logic         audio_clk;

   logic         wait_a, iso_a, stall_a, ovf_a, unf_a, ferr_a;
   logic [31:0]  audio_a;
   logic [6:0]   fill_a;
   logic         wait_b, iso_b, stall_b, ovf_b, unf_b, ferr_b;
   logic [143:0] audio_b;
   logic [3:0]   fill_b;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: frame queues, run flags and expected Audio per instance.
   logic [31:0]  mq_a[$];
   logic [143:0] mq_b[$];
   bit           run_a = 1'b0;
   bit           run_b = 1'b0;
   logic [31:0]  exp_audio_a = '0;
   logic [143:0] exp_audio_b = '0;

   always #5 clk = ~clk;

   usb_stream_multi #(.CHANNELS(2), .SAMPLE_BYTES(2), .FIFO_DEPTH(DEPTH_A)) dut_a (
      .Clk(clk), .nReset(n_reset), .Enable(enable_a),
      .OUT_SoP(out_sop), .OUT_EoP(out_eop), .OUT_Data(out_data), .OUT_Valid(out_valid),
      .OUT_WaitRequest(wait_a), .OUT_Isochronous(iso_a), .Stall(stall_a),
      .Audio_Clk(audio_clk), .Audio(audio_a), .Fill(fill_a),
      .Overflow(ovf_a), .Underflow(unf_a), .FrameError(ferr_a)
   );

   usb_stream_multi #(.CHANNELS(6), .SAMPLE_BYTES(3), .FIFO_DEPTH(DEPTH_B)) dut_b (
      .Clk(clk), .nReset(n_reset), .Enable(enable_b),
      .OUT_SoP(out_sop), .OUT_EoP(out_eop), .OUT_Data(out_data), .OUT_Valid(out_valid),
      .OUT_WaitRequest(wait_b), .OUT_Isochronous(iso_b), .Stall(stall_b),
      .Audio_Clk(audio_clk), .Audio(audio_b), .Fill(fill_b),
      .Overflow(ovf_b), .Underflow(unf_b), .FrameError(ferr_b)
   );

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model_a();
      mq_a.delete();
      run_a       = 1'b0;
      exp_audio_a = '0;
   endtask

   task automatic clear_model_b();
      mq_b.delete();
      run_b       = 1'b0;
      exp_audio_b = '0;
   endtask

   task automatic drive_byte(input logic [7:0] d, input logic sop, input logic eop);
      out_data  = d;
      out_valid = 1'b1;
      out_sop   = sop;
      out_eop   = eop;
      cycle();
      out_valid = 1'b0;
      out_sop   = 1'b0;
      out_eop   = 1'b0;
   endtask

   // One packet of n whole frames to instance A (to_b=0) or B (to_b=1).
   task automatic send_frames(input bit to_b, input int n, input logic [143:0] fixed,
                              input bit use_fixed);
      int nb;
      nb = to_b ? 18 : 4;
      for (int f = 0; f < n; f++) begin
         logic [143:0] fr;
         bit           exp_ovf;
         fr = '0;
         for (int i = 0; i < nb; i++)
            fr[i*8 +: 8] = use_fixed ? fixed[i*8 +: 8] : 8'($urandom);
         for (int i = 0; i < nb; i++)
            drive_byte(fr[i*8 +: 8], (f == 0) && (i == 0), (f == n - 1) && (i == nb - 1));
         if (to_b) begin
            exp_ovf = (mq_b.size() == DEPTH_B);
            if (!exp_ovf) mq_b.push_back(fr);
            n_cmp++;
            if (ovf_b !== exp_ovf) begin
               n_bad++; $display("FAIL ovf_b: got %b expected %b", ovf_b, exp_ovf);
            end
            n_cmp++;
            if (ferr_b !== 1'b0) begin
               n_bad++; $display("FAIL ferr_b: got %b expected 0", ferr_b);
            end
            n_cmp++;
            if (fill_b !== 4'(mq_b.size())) begin
               n_bad++; $display("FAIL fill_b: got %0d expected %0d", fill_b, mq_b.size());
            end
         end else begin
            exp_ovf = (mq_a.size() == DEPTH_A);
            if (!exp_ovf) mq_a.push_back(fr[31:0]);
            n_cmp++;
            if (ovf_a !== exp_ovf) begin
               n_bad++; $display("FAIL ovf_a: got %b expected %b", ovf_a, exp_ovf);
            end
            n_cmp++;
            if (ferr_a !== 1'b0) begin
               n_bad++; $display("FAIL ferr_a: got %b expected 0", ferr_a);
            end
            n_cmp++;
            if (fill_a !== 7'(mq_a.size())) begin
               n_bad++; $display("FAIL fill_a: got %0d expected %0d", fill_a, mq_a.size());
            end
         end
      end
   endtask

   // One Audio_Clk period; model decides pop / hold / underflow for both instances.
   task automatic tick();
      int   ua;
      int   ub;
      bit   exp_ua;
      bit   exp_ub;
      exp_ua = 1'b0;
      exp_ub = 1'b0;
      if (!run_a && mq_a.size() >= DEPTH_A / 2) run_a = 1'b1;
      if (run_a) begin
         if (mq_a.size() > 0) exp_audio_a = mq_a.pop_front();
         else begin exp_ua = 1'b1; exp_audio_a = '0; run_a = 1'b0; end
      end
      if (!run_b && mq_b.size() >= DEPTH_B / 2) run_b = 1'b1;
      if (run_b) begin
         if (mq_b.size() > 0) exp_audio_b = mq_b.pop_front();
         else begin exp_ub = 1'b1; exp_audio_b = '0; run_b = 1'b0; end
      end
      audio_clk = 1'b1;
      repeat (3) cycle();
      audio_clk = 1'b0;
      ua = 0;
      ub = 0;
      repeat (4) begin
         cycle();
         if (unf_a === 1'b1) ua++;
         if (unf_b === 1'b1) ub++;
      end
      n_cmp++;
      if (ua != int'(exp_ua)) begin
         n_bad++; $display("FAIL unf_a: pulses %0d expected %0d", ua, exp_ua);
      end
      n_cmp++;
      if (ub != int'(exp_ub)) begin
         n_bad++; $display("FAIL unf_b: pulses %0d expected %0d", ub, exp_ub);
      end
      n_cmp++;
      if (audio_a !== exp_audio_a) begin
         n_bad++; $display("FAIL audio_a: got %h expected %h", audio_a, exp_audio_a);
      end
      n_cmp++;
      if (audio_b !== exp_audio_b) begin
         n_bad++; $display("FAIL audio_b: got %h expected %h", audio_b, exp_audio_b);
      end
      n_cmp++;
      if (fill_a !== 7'(mq_a.size())) begin
         n_bad++; $display("FAIL tick fill_a: got %0d expected %0d", fill_a, mq_a.size());
      end
      n_cmp++;
      if (fill_b !== 4'(mq_b.size())) begin
         n_bad++; $display("FAIL tick fill_b: got %0d expected %0d", fill_b, mq_b.size());
      end
   endtask

   // Drop Enable for a cycle (checking the flush), then re-enable instance A.
   task automatic reenable_a();
      enable_a = 1'b0;
      cycle();
      clear_model_a();
      n_cmp++;
      if (fill_a !== 7'd0 || audio_a !== 32'd0) begin
         n_bad++; $display("FAIL disable_a: fill %0d audio %h expected 0/0", fill_a, audio_a);
      end
      enable_a = 1'b1;
      repeat (2) cycle();
   endtask

   task automatic test_reset();
      n_reset   = 1'b0;
      enable_a  = 1'b0;
      enable_b  = 1'b0;
      out_sop   = 1'b0;
      out_eop   = 1'b0;
      out_data  = '0;
      out_valid = 1'b0;
      audio_clk = 1'b0;
      repeat (2) cycle();
      n_cmp++;
      if ({audio_a, fill_a, ovf_a, unf_a, ferr_a} !== '0) begin
         n_bad++; $display("FAIL reset_a: audio %h fill %0d pulses %b%b%b expected 0",
                           audio_a, fill_a, ovf_a, unf_a, ferr_a);
      end
      n_cmp++;
      if ({audio_b, fill_b, ovf_b, unf_b, ferr_b} !== '0) begin
         n_bad++; $display("FAIL reset_b: audio %h fill %0d expected 0", audio_b, fill_b);
      end
      n_cmp++;
      if ({wait_a, iso_a, stall_a, wait_b, iso_b, stall_b} !== 6'b010_010) begin
         n_bad++; $display("FAIL ties: got %b%b%b %b%b%b expected 010 010",
                           wait_a, iso_a, stall_a, wait_b, iso_b, stall_b);
      end
      n_reset = 1'b1;
      cycle();
   endtask

   task automatic test_stereo_stream();
      enable_a = 1'b1;
      repeat (2) cycle();
      send_frames(1'b0, 16, 144'hABCD_1234, 1'b1);
      send_frames(1'b0, 15, 144'hABCD_1234, 1'b1);
      tick();
      send_frames(1'b0, 1, 144'hABCD_1234, 1'b1);
      repeat (3) begin
         tick();
         n_cmp++;
         if (audio_a !== 32'hABCD_1234) begin
            n_bad++; $display("FAIL stereo_const: got %h expected abcd1234", audio_a);
         end
      end
      for (int k = 0; k < 30; k++) begin
         if ($urandom_range(0, 1) == 1) send_frames(1'b0, int'($urandom_range(1, 3)), '0, 1'b0);
         else tick();
      end
   endtask

   task automatic test_frame_error();
      reenable_a();
      drive_byte(8'h34, 1'b1, 1'b0);
      drive_byte(8'h12, 1'b0, 1'b0);
      drive_byte(8'hCD, 1'b0, 1'b0);
      drive_byte(8'hAB, 1'b0, 1'b0);
      mq_a.push_back(32'hABCD_1234);
      n_cmp++;
      if (fill_a !== 7'd1) begin
         n_bad++; $display("FAIL ferr_push: fill %0d expected 1", fill_a);
      end
      drive_byte(8'h55, 1'b0, 1'b1);
      n_cmp++;
      if (ferr_a !== 1'b1 || fill_a !== 7'd1) begin
         n_bad++; $display("FAIL ferr_pulse: ferr %b fill %0d expected 1/1", ferr_a, fill_a);
      end
      cycle();
      n_cmp++;
      if (ferr_a !== 1'b0) begin
         n_bad++; $display("FAIL ferr_width: got %b expected 0", ferr_a);
      end
      drive_byte(8'h77, 1'b1, 1'b0);
      drive_byte(8'h88, 1'b0, 1'b0);
      send_frames(1'b0, 1, '0, 1'b0);
      send_frames(1'b0, 30, '0, 1'b0);
      repeat (2) tick();
   endtask

   task automatic test_overflow_underflow();
      reenable_a();
      send_frames(1'b0, 64, '0, 1'b0);
      send_frames(1'b0, 1, '0, 1'b0);
      n_cmp++;
      if (ovf_a !== 1'b1 || fill_a !== 7'd64) begin
         n_bad++; $display("FAIL overflow: ovf %b fill %0d expected 1/64", ovf_a, fill_a);
      end
      repeat (65) tick();
      n_cmp++;
      if (audio_a !== 32'd0) begin
         n_bad++; $display("FAIL underflow_audio: got %h expected 0", audio_a);
      end
      send_frames(1'b0, 31, '0, 1'b0);
      tick();
      send_frames(1'b0, 1, '0, 1'b0);
      tick();
   endtask

   task automatic test_enable_drop();
      while (mq_a.size() > 20) tick();
      drive_byte(8'h11, 1'b1, 1'b0);
      drive_byte(8'h22, 1'b0, 1'b0);
      enable_a = 1'b0;
      drive_byte(8'h33, 1'b0, 1'b0);
      clear_model_a();
      n_cmp++;
      if (fill_a !== 7'd0 || audio_a !== 32'd0) begin
         n_bad++; $display("FAIL enable_drop: fill %0d audio %h expected 0/0", fill_a, audio_a);
      end
      drive_byte(8'h44, 1'b0, 1'b1);
      n_cmp++;
      if (fill_a !== 7'd0 || ferr_a !== 1'b0) begin
         n_bad++; $display("FAIL enable_rest: fill %0d ferr %b expected 0/0", fill_a, ferr_a);
      end
      enable_a = 1'b1;
      repeat (2) cycle();
   endtask

   task automatic test_async_reset();
      send_frames(1'b0, 1, 144'h0F0F_F0F0, 1'b1);
      send_frames(1'b0, 31, '0, 1'b0);
      tick();
      #2;
      n_reset = 1'b0;
      #1;
      n_cmp++;
      if ({audio_a, fill_a, ovf_a, unf_a, ferr_a} !== '0) begin
         n_bad++; $display("FAIL async_reset: audio %h fill %0d expected 0", audio_a, fill_a);
      end
      cycle();
      n_reset = 1'b1;
      clear_model_a();
      repeat (2) cycle();
   endtask

   task automatic test_six_channel();
      logic [143:0] fixed;
      enable_a = 1'b0;
      enable_b = 1'b1;
      clear_model_a();
      repeat (2) cycle();
      for (int k = 0; k < 6; k++) fixed[k*24 +: 24] = 24'h0A0B00 + 24'(k);
      send_frames(1'b1, 1, fixed, 1'b1);
      send_frames(1'b1, 3, '0, 1'b0);
      tick();
      for (int k = 0; k < 6; k++) begin
         n_cmp++;
         if (audio_b[k*24 +: 24] !== 24'h0A0B00 + 24'(k)) begin
            n_bad++; $display("FAIL six_ch%0d: got %h expected %h", k, audio_b[k*24 +: 24],
                              24'h0A0B00 + 24'(k));
         end
      end
      send_frames(1'b1, 8, '0, 1'b0);
      repeat (9) tick();
   endtask

   initial begin
      test_reset();
      test_stereo_stream();
      test_frame_error();
      test_overflow_underflow();
      test_enable_drop();
      test_async_reset();
      test_six_channel();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
